// File: rtl/ysyx_25040109_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem fetch at a time and
// hands the returned word to the IDU over a valid/ready handshake.
module ysyx_25040109_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  // Handshake: the IDU takes inst/inst_pc in any cycle where inst_valid and
  // inst_ready are both high; inst/inst_pc hold steady while inst_valid waits.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic        take;
  logic [15:0] wcnt;
  logic [31:0] redir_target;

  assign redir_target = {redirect_pc[31:2], 2'b00};
  assign imem_addr    = pc;
  assign dbg_state    = state;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    take    = 1'b0;
    case (state)
      S_IDLE: state_n = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          // A killed or redirected response is dropped; the next request
          // goes out the following cycle from the (possibly new) pc.
          if (kill || redirect_valid) begin
            kill_n = 1'b0;
            if (redirect_valid) pc_n = redir_target;
          end else begin
            take    = 1'b1;
            state_n = S_VALID;
          end
        end else if (redirect_valid) begin
          pc_n   = redir_target;
          kill_n = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          pc_n    = redir_target;
          state_n = S_WAIT;
        end else if (inst_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      wcnt       <= 16'd0;
      imem_ren   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      fetch_err  <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      kill       <= kill_n;
      imem_ren   <= (state_n == S_WAIT);
      inst_valid <= (state_n == S_VALID);
      if (take) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      // Watchdog counts cycles since entering S_WAIT and saturates at TIMEOUT.
      if (state_n == S_WAIT && state != S_WAIT) begin
        wcnt <= 16'd0;
      end else if (state == S_WAIT && wcnt != TIMEOUT) begin
        wcnt <= wcnt + 16'd1;
      end
      if (state == S_WAIT && wcnt == TIMEOUT) fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Directed bench for the IFU: a 2-cycle-latency fetch memory model and
// scenario tasks that check handshake, redirect, wrap and watchdog behaviour.
module tb_ysyx_25040109_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;

  ysyx_25040109_ifu dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_ren(imem_ren),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: accepts a request when ren is seen at a posedge while idle,
  // returns rvalid for one cycle two cycles after the request cycle.
  logic        busy = 1'b0;
  logic        mem_dead = 1'b0;
  logic        mem_flush = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        ren_s;
  logic [31:0] addr_s;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
  end

  always @(posedge clk) begin
    ren_s  = imem_ren;
    addr_s = imem_addr;
    #1;
    if (mem_flush) begin
      busy = 1'b0;
      imem_rvalid = 1'b0;
    end else if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      busy = 1'b0;
    end else if (busy) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(req_addr);
    end else if (ren_s && !mem_dead) begin
      busy = 1'b1;
      req_addr = addr_s;
    end
  end

  // driver tasks
  // Leaves the bench at the negedge of "cycle 0": rst just released, DUT still idle.
  task automatic do_reset();
    rst = 1'b1;
    mem_flush = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_flush = 1'b0;
    total++; if (imem_ren !== 1'b0) $display("FAIL rst_ren got=%b exp=0", imem_ren); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", inst_valid); else passed++;
    total++; if (inst !== 32'd0 || inst_pc !== 32'd0)
      $display("FAIL rst_inst got=%h/%h exp=0/0", inst, inst_pc); else passed++;
    total++; if (fetch_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", fetch_err); else passed++;
    total++; if (imem_addr !== 32'h8000_0000) $display("FAIL rst_addr got=%h exp=80000000", imem_addr); else passed++;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc);
    int cyc = 0;
    while (inst_valid !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (inst_valid !== 1'b1) $display("FAIL wait_valid_timeout got=%b exp=1", inst_valid); else passed++;
  endtask

  // scenarios
  task automatic test_basic_fetch();
    do_reset();
    @(negedge clk);
    total++; if (imem_ren !== 1'b1 || imem_addr !== 32'h8000_0000)
      $display("FAIL c1_req got=%b/%h exp=1/80000000", imem_ren, imem_addr); else passed++;
    for (int c = 1; c <= 3; c++) begin
      total++; if (inst_valid !== 1'b0) $display("FAIL early_valid c%0d got=%b exp=0", c, inst_valid); else passed++;
      @(negedge clk);
    end
    total++; if (inst_valid !== 1'b1) $display("FAIL c4_valid got=%b exp=1", inst_valid); else passed++;
    total++; if (inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000)
      $display("FAIL c4_inst got=%h/%h exp=00000413/80000000", inst, inst_pc); else passed++;
    total++; if (imem_ren !== 1'b0) $display("FAIL c4_ren got=%b exp=0", imem_ren); else passed++;
    @(negedge clk);
    total++; if (imem_ren !== 1'b1 || imem_addr !== 32'h8000_0004)
      $display("FAIL c5_next got=%b/%h exp=1/80000004", imem_ren, imem_addr); else passed++;
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) $display("FAIL c7_valid got=%b exp=0", inst_valid); else passed++;
    @(negedge clk);
    total++; if (inst_valid !== 1'b1) $display("FAIL c8_valid got=%b exp=1", inst_valid); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (inst_valid !== 1'b1 || imem_ren !== 1'b0)
        $display("FAIL hold_ctl i%0d got=%b/%b exp=1/0", i, inst_valid, imem_ren); else passed++;
      total++; if (inst !== mem_word(32'h8000_0004) || inst_pc !== 32'h8000_0004)
        $display("FAIL hold_data i%0d got=%h/%h exp=%h/80000004", i, inst, inst_pc, mem_word(32'h8000_0004)); else passed++;
      total++; if (imem_addr !== 32'h8000_0004) $display("FAIL hold_pc i%0d got=%h exp=80000004", i, imem_addr); else passed++;
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0 || imem_ren !== 1'b1 || imem_addr !== 32'h8000_0008)
      $display("FAIL accept_next got=%b/%b/%h exp=0/1/80000008", inst_valid, imem_ren, imem_addr); else passed++;
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      total++; if (inst_valid !== 1'b0) $display("FAIL kill_valid c%0d got=%b exp=0", c, inst_valid); else passed++;
      if (c == 4) begin
        total++; if (imem_ren !== 1'b1 || imem_addr !== 32'h8000_0100)
          $display("FAIL kill_req got=%b/%h exp=1/80000100", imem_ren, imem_addr); else passed++;
      end
      @(negedge clk);
    end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst !== mem_word(32'h8000_0100))
      $display("FAIL redir_deliver got=%b/%h/%h exp=1/80000100/%h", inst_valid, inst_pc, inst, mem_word(32'h8000_0100));
    else passed++;
  endtask

  task automatic test_redirect_over_ready();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if (inst_valid !== 1'b0 || imem_ren !== 1'b1 || imem_addr !== 32'h8000_0200)
      $display("FAIL redir_prio got=%b/%b/%h exp=0/1/80000200", inst_valid, imem_ren, imem_addr); else passed++;
    wait_valid(10);
    total++; if (inst_pc !== 32'h8000_0200) $display("FAIL redir_pc got=%h exp=80000200", inst_pc); else passed++;
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_mask got=%h exp=fffffffc", imem_addr); else passed++;
    wait_valid(10);
    total++; if (inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got=%h exp=fffffffc", inst_pc); else passed++;
    @(negedge clk);
    total++; if (imem_ren !== 1'b1 || imem_addr !== 32'h0000_0000)
      $display("FAIL wrap_addr got=%b/%h exp=1/00000000", imem_ren, imem_addr); else passed++;
    wait_valid(10);
    total++; if (inst_pc !== 32'd0 || inst !== mem_word(32'd0))
      $display("FAIL wrap_inst got=%h/%h exp=00000000/%h", inst_pc, inst, mem_word(32'd0)); else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0 || imem_ren !== 1'b0)
      $display("FAIL midrst_idle got=%b/%b exp=0/0", inst_valid, imem_ren); else passed++;
    rst = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      total++; if (inst_valid !== 1'b0) $display("FAIL midrst_stale c%0d got=%b exp=0", c, inst_valid); else passed++;
    end
    @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 || inst !== 32'h0000_0413)
      $display("FAIL midrst_deliver got=%b/%h/%h exp=1/80000000/00000413", inst_valid, inst_pc, inst); else passed++;
  endtask

  task automatic test_timeout();
    mem_dead = 1'b1;
    do_reset();
    repeat (1020) @(negedge clk);
    total++; if (fetch_err !== 1'b0 || imem_ren !== 1'b1)
      $display("FAIL wd_early got=%b/%b exp=0/1", fetch_err, imem_ren); else passed++;
    repeat (10) @(negedge clk);
    total++; if (fetch_err !== 1'b1) $display("FAIL wd_set got=%b exp=1", fetch_err); else passed++;
    repeat (20) @(negedge clk);
    total++; if (fetch_err !== 1'b1 || imem_ren !== 1'b1 || imem_addr !== 32'h8000_0000)
      $display("FAIL wd_sticky got=%b/%b/%h exp=1/1/80000000", fetch_err, imem_ren, imem_addr); else passed++;
    mem_dead = 1'b0;
    do_reset();
    wait_valid(10);
    total++; if (inst_pc !== 32'h8000_0000 || fetch_err !== 1'b0)
      $display("FAIL wd_restart got=%h/%b exp=80000000/0", inst_pc, fetch_err); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    test_basic_fetch();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_over_ready();
    test_pc_wrap();
    test_reset_mid_fetch();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
